hex_display_ctrl: RTL



---
 rtl/hex_display_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: arbitrates two requesters onto the 28-bit hex-display PIO
// (four active-low 7-segment digits) through a write-only Avalon-MM master.
// req0 has priority and may preempt the display hold that protects req1 values.
// Optional feature macro: HEX_CTRL_BLANK_EN (leading-zero blanking of digits 3..1).
module hex_display_ctrl #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  output logic        busy,
  output logic        last_src
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic             accept0;
  logic             accept1;

  // Active-low segment pattern for one hex nibble; bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Full four-digit pattern, digit 3 in the top seven bits.
  function automatic logic [27:0] encode(input logic [15:0] value);
    logic [27:0] pat;
    pat = {seg7(value[15:12]), seg7(value[11:8]), seg7(value[7:4]), seg7(value[3:0])};
`ifdef HEX_CTRL_BLANK_EN
    // Blank zero digits from the top until the first non-zero one; digit 0 always shows.
    if (value[15:12] == 4'h0) begin
      pat[27:21] = 7'h7F;
      if (value[11:8] == 4'h0) begin
        pat[20:14] = 7'h7F;
        if (value[7:4] == 4'h0) begin
          pat[13:7] = 7'h7F;
        end
      end
    end
`endif
    return pat;
  endfunction

  assign accept0     = req0_valid & req0_ready;
  assign accept1     = req1_valid & req1_ready;
  assign avm_address = 2'b00;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: req0 always wins, req1 is only taken from IDLE.
  // NOTE: a default assignment up front keeps this block from inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept0 || accept1) state_next = WRITE;
      WRITE:   state_next = (last_src && (HOLD_CYCLES != 0)) ? HOLD : IDLE;
      HOLD: begin
        if (accept0)             state_next = WRITE;
        else if (hold_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready and busy outputs, combinational from state and req0_valid.
  always_comb begin
    req0_ready = (state != WRITE);
    req1_ready = (state == IDLE) && !req0_valid;
    busy       = (state != IDLE);
  end

  // Latch the encoded pattern and its source on every accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_writedata <= '0;
      last_src      <= 1'b0;
    end else if (accept0 || accept1) begin
      avm_writedata <= {4'h0, encode(accept0 ? req0_data : req1_data)};
      last_src      <= !accept0;
    end
  end

  // Registered write strobe: asserted exactly in the cycle spent in WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
    end else begin
      avm_chipselect <= (state_next == WRITE);
      avm_write_n    <= (state_next != WRITE);
    end
  end

  // Hold counter: loaded as a req1 write goes out, counts down while nothing preempts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (state == WRITE && last_src && (HOLD_CYCLES != 0)) begin
      hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
    end else if (state == HOLD && !accept0 && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

endmodule
